axi_remap_ctrl: RTL
===================

Name: axi_remap_ctrl

Overview:
- Rule-based address remapper and reconfiguration sequencer for an AXI address-modify stage.
- Combinationally translates AW/AR addresses through a NUM_RULES-entry base/mask/target table.
- Accepts table updates through a req/gnt port. Before each update it quiesces the AXI port: it gates new AW/AR requests legally and waits for outstanding writes and reads to drain, so no transaction ever sees two mappings.

Parameters:
- ADDR_WIDTH, 32, width of input and output addresses
- NUM_RULES, 4, number of remap rules (>=1)
- MAX_TXNS, 8, max outstanding writes and max outstanding reads tracked per direction (>=1)
- DRAIN_TIMEOUT, 1024, drain cycle limit (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- aw_valid_i / aw_ready_i  in  1 / 1  AW handshake, observed upstream of gating
- ar_valid_i / ar_ready_i  in  1 / 1  AR handshake, observed upstream of gating
- b_valid_i / b_ready_i  in  1 / 1  B handshake
- r_valid_i / r_ready_i / r_last_i  in  1 / 1 / 1  R handshake
- aw_addr_in_i / ar_addr_in_i  in  ADDR_WIDTH  untranslated addresses
- aw_addr_out_o / ar_addr_out_o  out  ADDR_WIDTH  translated addresses
- aw_stall_o / ar_stall_o  out  1  the wrapper forces downstream valid and upstream ready low while set
- cfg_req_i  in  1  update request; held until cfg_gnt_o
- cfg_idx_i  in  max(1,$clog2(NUM_RULES))  rule index
- cfg_en_i  in  1  rule enable
- cfg_base_i / cfg_mask_i / cfg_target_i  in  ADDR_WIDTH  match base, match mask (1 = compared bit), replacement base
- cfg_gnt_o  out  1  one-cycle completion pulse
- cfg_err_o  out  1  valid with cfg_gnt_o; 1 = update aborted
- busy_o  out  1  state != IDLE

Behaviour:
- Clocking and reset:
  - One clock, clk_i; reset rst_i is synchronous and active-high.
  - Reset clears all rule enables (table contents otherwise don't-care), both counters, both stalls, cfg_gnt_o, cfg_err_o; state goes to IDLE.
  - A pending cfg_req_i at reset is dropped; the requester re-requests.
- Translation (zero latency):
  - Rule k hits when en[k] and (addr & mask[k]) == (base[k] & mask[k]).
  - The lowest hit index wins. Output = (target[k] & mask[k]) | (addr & ~mask[k]).
  - No hit: output = input.
- Counters:
  - aw_cnt: +1 on aw_valid_i&aw_ready_i, -1 on b_valid_i&b_ready_i.
  - ar_cnt: +1 on AR handshake, -1 on R handshake with r_last_i.
  - Simultaneous increment and decrement leaves the count unchanged. Width $clog2(MAX_TXNS+1).
  - Decrement at 0 is an assertion failure (non-synthesis); the counter holds at 0.
- Stall rule (AXI-legal gating):
  - A stall may rise at a clock edge only if that channel has no unaccepted valid in the current cycle, i.e. !valid | ready.
  - aw_stall_o is also requested whenever aw_cnt == MAX_TXNS; ar_stall_o likewise with ar_cnt. Both are subject to the same legality rule.
  - Stalls are registered outputs.
- FSM:
  - IDLE: cfg_req_i -> DRAIN; drain stalls are requested from this edge.
  - DRAIN: stalls rise when legal. When aw_stall&ar_stall&aw_cnt==0&ar_cnt==0 -> UPDATE.
  - UPDATE: write rule cfg_idx_i and assert cfg_gnt_o=1, cfg_err_o=0 for this cycle. The new table is visible next cycle; stalls drop next cycle unless the MAX_TXNS saturation rule still holds. -> IDLE.
  - cfg_idx_i >= NUM_RULES: no write, cfg_err_o=1 with the grant.
  - Request changes before the grant are illegal; the write uses values sampled in UPDATE.
- Latency: on an idle bus with no pending valids, request at cycle 0 gives grant at cycle 2 and the new mapping at cycle 3.
- Simultaneous events:
  - A handshake in the same cycle stalls rise is counted.
  - B/R traffic is never gated.
  - cfg_req_i during UPDATE is treated as a new request only after returning to IDLE.

Optional Feature:
- Macro: AXI_REMAP_CTRL_TIMEOUT_EN.
- Defined:
  - A drain cycle counter starts on DRAIN entry.
  - If DRAIN_TIMEOUT cycles elapse without reaching UPDATE, the FSM goes to an ABORT state for one cycle: cfg_gnt_o=1, cfg_err_o=1, no table write.
  - Stalls are released next cycle.
- Not defined: DRAIN waits indefinitely and the DRAIN_TIMEOUT parameter is ignored.

Test Plan:
1. Translation priority: rule0 base 0x1000_0000 mask 0xF000_0000 target 0x8000_0000; rule1 base 0x1200_0000 mask 0xFF00_0000 target 0x4000_0000. aw_addr_in 0x1234_5678 -> 0x8234_5678 (rule0 wins); with rule0 disabled -> 0x4034_5678; 0x2000_0000 -> unchanged.
2. Idle update: req at cycle 0 on an idle bus -> stalls high at cycle 1, gnt pulse at cycle 2 with err 0, new mapping at cycle 3, stalls low at cycle 3.
3. Drain with traffic: 3 writes outstanding, then req -> no grant until 3 B handshakes. An AW held valid&!ready at req keeps aw_stall_o low until accepted; that AW is counted, giving 4 Bs before the grant.
4. Saturation: MAX_TXNS=2, issue 2 ARs with no R -> ar_stall_o high. One R beat with r_last -> ar_stall_o low next cycle. Simultaneous AR and R-last at count 1 -> count stays 1.
5. Reset mid-drain: rst_i asserted in DRAIN with aw_cnt=2 -> next cycle state IDLE, stalls 0, counts 0, all rules disabled, no grant pulse.
6. (AXI_REMAP_CTRL_TIMEOUT_EN, DRAIN_TIMEOUT=16) req with a write never responded -> gnt=1 with err=1 after 16 DRAIN cycles; table unchanged; stalls released.

Source files
------------

// File: rtl/axi_remap_ctrl.sv
// axi_remap_ctrl: rule-based AW/AR address remapper with a quiesce-then-update
// reconfiguration sequencer. Table updates arrive on a req/gnt port; before a
// rule is written, new AW/AR requests are gated (only when gating is legal)
// and outstanding writes/reads are drained, so no transaction sees two maps.
//
// Valid/ready semantics: a channel transfers on a cycle where valid & ready
// are both high. A valid, once raised, stays high until that transfer, so a
// stall may only rise when the channel has no unaccepted valid this cycle
// (!valid | ready).
//
// Optional feature macro: AXI_REMAP_CTRL_TIMEOUT_EN (drain timeout -> ABORT).
module axi_remap_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter int NUM_RULES     = 4,
  parameter int MAX_TXNS      = 8,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       aw_valid_i,
  input  logic                                       aw_ready_i,
  input  logic                                       ar_valid_i,
  input  logic                                       ar_ready_i,
  input  logic                                       b_valid_i,
  input  logic                                       b_ready_i,
  input  logic                                       r_valid_i,
  input  logic                                       r_ready_i,
  input  logic                                       r_last_i,
  input  logic [ADDR_WIDTH-1:0]                      aw_addr_in_i,
  input  logic [ADDR_WIDTH-1:0]                      ar_addr_in_i,
  output logic [ADDR_WIDTH-1:0]                      aw_addr_out_o,
  output logic [ADDR_WIDTH-1:0]                      ar_addr_out_o,
  output logic                                       aw_stall_o,
  output logic                                       ar_stall_o,
  input  logic                                       cfg_req_i,
  input  logic [((NUM_RULES > 1) ? $clog2(NUM_RULES) : 1)-1:0] cfg_idx_i,
  input  logic                                       cfg_en_i,
  input  logic [ADDR_WIDTH-1:0]                      cfg_base_i,
  input  logic [ADDR_WIDTH-1:0]                      cfg_mask_i,
  input  logic [ADDR_WIDTH-1:0]                      cfg_target_i,
  output logic                                       cfg_gnt_o,
  output logic                                       cfg_err_o,
  output logic                                       busy_o
);

  localparam int IW = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
  localparam int CW = $clog2(MAX_TXNS + 1);
  localparam logic [IW:0]   NUM_RULES_L = (IW + 1)'(NUM_RULES);
  localparam logic [CW-1:0] MAX_TXNS_L  = CW'(MAX_TXNS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_UPDATE = 2'd2,
    S_ABORT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         aw_cnt_q, aw_cnt_d;
  logic [CW-1:0]         ar_cnt_q, ar_cnt_d;
  logic                  aw_stall_q, aw_stall_d;
  logic                  ar_stall_q, ar_stall_d;
  logic [NUM_RULES-1:0]  en_q;
  logic [ADDR_WIDTH-1:0] base_q   [NUM_RULES];
  logic [ADDR_WIDTH-1:0] mask_q   [NUM_RULES];
  logic [ADDR_WIDTH-1:0] target_q [NUM_RULES];

  logic aw_inc, aw_dec, ar_inc, ar_dec;
  logic drain_req, tbl_we, idx_ok;

  assign aw_inc = aw_valid_i & aw_ready_i;
  assign aw_dec = b_valid_i & b_ready_i;
  assign ar_inc = ar_valid_i & ar_ready_i;
  assign ar_dec = r_valid_i & r_ready_i & r_last_i;
  assign idx_ok = ({1'b0, cfg_idx_i} < NUM_RULES_L);

  // Lowest-index hit wins: scan from the top so lower rules overwrite.
  function automatic logic [ADDR_WIDTH-1:0] xlate(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    r = a;
    for (int k = NUM_RULES - 1; k >= 0; k--) begin
      if (en_q[k] && ((a & mask_q[k]) == (base_q[k] & mask_q[k]))) begin
        r = (target_q[k] & mask_q[k]) | (a & ~mask_q[k]);
      end
    end
    return r;
  endfunction

  // Zero-latency address translation through the current rule table.
  always_comb begin
    aw_addr_out_o = xlate(aw_addr_in_i);
    ar_addr_out_o = xlate(ar_addr_in_i);
  end

  // Outstanding-transaction counters; a simultaneous +1/-1 cancels, and a
  // decrement with nothing outstanding holds at zero.
  always_comb begin
    aw_cnt_d = aw_cnt_q;
    ar_cnt_d = ar_cnt_q;
    if (aw_inc && !aw_dec)                        aw_cnt_d = aw_cnt_q + CW'(1);
    else if (aw_dec && !aw_inc && aw_cnt_q != '0) aw_cnt_d = aw_cnt_q - CW'(1);
    if (ar_inc && !ar_dec)                        ar_cnt_d = ar_cnt_q + CW'(1);
    else if (ar_dec && !ar_inc && ar_cnt_q != '0) ar_cnt_d = ar_cnt_q - CW'(1);
  end

`ifdef AXI_REMAP_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DRAIN_TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Drain cycle counter: zero on DRAIN entry, counts every DRAIN cycle.
  always_comb begin
    tmo_d = '0;
    if (state_q == S_DRAIN) tmo_d = tmo_q + TW'(1);
  end

  // Drain cycle counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  // Sequencer next state and grant/error outputs.
  always_comb begin
    state_d   = state_q;
    drain_req = 1'b0;
    tbl_we    = 1'b0;
    cfg_gnt_o = 1'b0;
    cfg_err_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_req_i) begin
          state_d   = S_DRAIN;
          drain_req = 1'b1;
        end
      end
      S_DRAIN: begin
        drain_req = 1'b1;
        if (aw_stall_q && ar_stall_q && aw_cnt_q == '0 && ar_cnt_q == '0) begin
          state_d = S_UPDATE;
        end
`ifdef AXI_REMAP_CTRL_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = S_ABORT;
        end
`endif
      end
      S_UPDATE: begin
        cfg_gnt_o = 1'b1;
        cfg_err_o = !idx_ok;
        tbl_we    = idx_ok;
        state_d   = S_IDLE;
      end
      S_ABORT: begin
        cfg_gnt_o = 1'b1;
        cfg_err_o = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall requests (drain or saturation at the post-edge count), raised only
  // when the channel holds no unaccepted valid; lowering is always allowed.
  always_comb begin
    aw_stall_d = (drain_req || aw_cnt_d == MAX_TXNS_L) &&
                 (aw_stall_q || !aw_valid_i || aw_ready_i);
    ar_stall_d = (drain_req || ar_cnt_d == MAX_TXNS_L) &&
                 (ar_stall_q || !ar_valid_i || ar_ready_i);
  end

  // State, counters, stalls and rule enables.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      aw_cnt_q   <= '0;
      ar_cnt_q   <= '0;
      aw_stall_q <= 1'b0;
      ar_stall_q <= 1'b0;
      en_q       <= '0;
    end else begin
      state_q    <= state_d;
      aw_cnt_q   <= aw_cnt_d;
      ar_cnt_q   <= ar_cnt_d;
      aw_stall_q <= aw_stall_d;
      ar_stall_q <= ar_stall_d;
      if (tbl_we) en_q[cfg_idx_i] <= cfg_en_i;
    end
  end

  // Rule contents carry no reset; only the enables matter after reset.
  always_ff @(posedge clk_i) begin
    if (tbl_we) begin
      base_q[cfg_idx_i]   <= cfg_base_i;
      mask_q[cfg_idx_i]   <= cfg_mask_i;
      target_q[cfg_idx_i] <= cfg_target_i;
    end
  end

  assign aw_stall_o = aw_stall_q;
  assign ar_stall_o = ar_stall_q;
  assign busy_o     = (state_q != S_IDLE);

`ifndef SYNTHESIS
  // Responses must never outnumber accepted requests.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(aw_dec && !aw_inc && aw_cnt_q == '0));
      assert (!(ar_dec && !ar_inc && ar_cnt_q == '0));
      assert (DRAIN_TIMEOUT > 0);
    end
  end
`endif

endmodule
